// File: rtl/video_memory_arbiter.sv
// video_memory_arbiter: owns the video SRAM and time-slices it between the
// display scan-out (guaranteed slot V every other clock) and a small FIFO of
// buffered CPU commands (slot C).
//
// Ports:
//   clock, reset            system clock (2x pixel clock), sync active-high reset
//   videoAddress            scan-out fetch address, sampled in slot V
//   videoData/Ready         fetched byte + one-cycle strobe (every 2 cycles)
//   cpuValid/Ready          CPU command handshake into the FIFO
//   cpuWrite                1 = write, 0 = read (read needs the macro below)
//   cpuAddress/WriteData    CPU command payload
//   cpuReadData/Valid       CPU read result + one-cycle strobe
//   fifoLevel               number of queued CPU commands
//   sramAddress/WriteData   SRAM address / write data (combinational decode)
//   sramWriteEnable         write at the end of this cycle
//   sramReadEnable          read; data appears on sramReadData next cycle
//   sramReadData            SRAM read data (1-cycle latency)
//
// Build option: define VIDEO_ARB_CPU_READ_EN to enable CPU read-back. Without
// it every CPU command is a write and cpuReadData/cpuReadValid stay at 0.
module video_memory_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [ADDR_WIDTH-1:0]         videoAddress,
  output logic [DATA_WIDTH-1:0]         videoData,
  output logic                          videoDataReady,
  input  logic                          cpuValid,
  output logic                          cpuReady,
  input  logic                          cpuWrite,
  input  logic [ADDR_WIDTH-1:0]         cpuAddress,
  input  logic [DATA_WIDTH-1:0]         cpuWriteData,
  output logic [DATA_WIDTH-1:0]         cpuReadData,
  output logic                          cpuReadValid,
  output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
  output logic [ADDR_WIDTH-1:0]         sramAddress,
  output logic [DATA_WIDTH-1:0]         sramWriteData,
  output logic                          sramWriteEnable,
  output logic                          sramReadEnable,
  input  logic [DATA_WIDTH-1:0]         sramReadData
);

  localparam int unsigned PTR_WIDTH   = $clog2(FIFO_DEPTH);
  localparam int unsigned LEVEL_WIDTH = PTR_WIDTH + 1;

  typedef enum logic {
    SLOT_V = 1'b0,
    SLOT_C = 1'b1
  } slot_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
`ifdef VIDEO_ARB_CPU_READ_EN
    logic                  isWrite;
`endif
  } cmd_t;

  slot_t                  slotState;
  slot_t                  slotNext;
  cmd_t                   cmdMem [FIFO_DEPTH];
  cmd_t                   pushCmd;
  cmd_t                   headCmd;
  logic [PTR_WIDTH-1:0]   wrPtr;
  logic [PTR_WIDTH-1:0]   rdPtr;
  logic                   push;
  logic                   popEn;
  logic                   headWrite;

  // FIFO accepts while not full; a simultaneous pop does not free a slot early.
  assign cpuReady = (fifoLevel != LEVEL_WIDTH'(FIFO_DEPTH));
  assign push     = cpuValid && cpuReady;
  assign headCmd  = cmdMem[rdPtr];

  // Command entry assembly.
  always_comb begin
    pushCmd         = '0;
    pushCmd.address = cpuAddress;
    pushCmd.data    = cpuWriteData;
`ifdef VIDEO_ARB_CPU_READ_EN
    pushCmd.isWrite = cpuWrite;
`endif
  end

`ifdef VIDEO_ARB_CPU_READ_EN
  assign headWrite = headCmd.isWrite;
`else
  assign headWrite = 1'b1;
  logic unusedCpuWrite;
  assign unusedCpuWrite = cpuWrite;
`endif

  // Slot register.
  always_ff @(posedge clock) begin
    if (reset) slotState <= SLOT_V;
    else       slotState <= slotNext;
  end

  // Slot sequencing and SRAM decode; reset masks both enables so nothing
  // commits while the arbiter is being flushed.
  always_comb begin
    slotNext        = (slotState == SLOT_V) ? SLOT_C : SLOT_V;
    sramAddress     = videoAddress;
    sramWriteData   = headCmd.data;
    sramWriteEnable = 1'b0;
    sramReadEnable  = 1'b0;
    popEn           = 1'b0;
    if (!reset) begin
      case (slotState)
        SLOT_V: sramReadEnable = 1'b1;
        SLOT_C: begin
          if (fifoLevel != '0) begin
            popEn           = 1'b1;
            sramAddress     = headCmd.address;
            sramWriteEnable = headWrite;
            sramReadEnable  = !headWrite;
          end
        end
        default: ;
      endcase
    end
  end

  // FIFO storage (no reset needed; validity is tracked by the level).
  always_ff @(posedge clock) begin
    if (push) cmdMem[wrPtr] <= pushCmd;
  end

  // FIFO pointers and level.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoLevel <= '0;
    end else begin
      if (push)  wrPtr <= wrPtr + PTR_WIDTH'(1);
      if (popEn) rdPtr <= rdPtr + PTR_WIDTH'(1);
      case ({push, popEn})
        2'b10:   fifoLevel <= fifoLevel + LEVEL_WIDTH'(1);
        2'b01:   fifoLevel <= fifoLevel - LEVEL_WIDTH'(1);
        default: fifoLevel <= fifoLevel;
      endcase
    end
  end

  // Display capture: slot C always carries the result of the slot V read.
  always_ff @(posedge clock) begin
    if (reset) begin
      videoData      <= '0;
      videoDataReady <= 1'b0;
    end else begin
      videoDataReady <= (slotState == SLOT_C);
      if (slotState == SLOT_C) videoData <= sramReadData;
    end
  end

`ifdef VIDEO_ARB_CPU_READ_EN
  logic readPending;

  // CPU read capture: a slot C read returns data during the following slot V.
  always_ff @(posedge clock) begin
    if (reset) begin
      readPending  <= 1'b0;
      cpuReadData  <= '0;
      cpuReadValid <= 1'b0;
    end else begin
      readPending  <= popEn && !headWrite;
      cpuReadValid <= (slotState == SLOT_V) && readPending;
      if ((slotState == SLOT_V) && readPending) cpuReadData <= sramReadData;
    end
  end
`else
  assign cpuReadData  = '0;
  assign cpuReadValid = 1'b0;
`endif

endmodule
